// File: rtl/r2n_buffer.sv
// r2n_buffer: reassembles block-tiled matmul output words into full matrix rows.
// Each input word carries NUM_CORES chunks of BLOCK_SIZE x BLOCK_SIZE elements; WPS
// words fill one slab of SLAB rows, which is then emitted one row per handshake.
// Optional feature macro: R2N_PINGPONG_EN (two slab banks, fill and drain overlap).
// Handshake: a transfer happens on a rising edge only when valid && ready; a
// producer holds valid and data stable until that edge.
module r2n_buffer #(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int ROW        = 2754,
    parameter int COL        = 256,
    parameter int NUM_CORES  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH*COL-1:0]                  out_data,
    output logic                                  out_last,
    output logic                                  frame_done,
    output logic [1:0]                            dbg_state
);
    localparam int SLAB = BLOCK_SIZE * NUM_CORES;
    localparam int WPS  = COL / BLOCK_SIZE;
    localparam int WC_W = (WPS > 1) ? $clog2(WPS) : 1;
    localparam int SR_W = (SLAB > 1) ? $clog2(SLAB) : 1;
    localparam int RC_W = (ROW > 1) ? $clog2(ROW) : 1;

    // Parameter sanity; fixed-point format is carried through untouched.
    if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_chk_chunk
        $error("r2n_buffer: CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
    end
    if (COL % BLOCK_SIZE != 0) begin : g_chk_col
        $error("r2n_buffer: COL must be a multiple of BLOCK_SIZE");
    end
    if (FRAC_WIDTH > WIDTH) begin : g_chk_frac
        $error("r2n_buffer: FRAC_WIDTH must not exceed WIDTH");
    end

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   word_cnt;
    logic [SR_W-1:0]   slab_row;
    logic [RC_W-1:0]   row_cnt;
    logic              fill_sel;
    logic              drain_sel;
    logic [1:0]        bank_full;
    logic [WIDTH-1:0]  bank [2][SLAB][COL];

    logic in_fire, out_fire, fill_last, row_last, slab_end, next_full;

`ifdef R2N_PINGPONG_EN
    // Accept words whenever the bank currently being filled is free.
    assign in_ready = !rst && !bank_full[fill_sel];
`else
    // Single bank: words are accepted only while filling.
    assign in_ready = !rst && (state_q == S_FILL);
`endif

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign fill_last = in_fire && (word_cnt == WC_W'(WPS - 1));
    assign row_last  = (row_cnt == RC_W'(ROW - 1));
    assign slab_end  = (slab_row == SR_W'(SLAB - 1));
    // The other bank is ready to drain now, or completes on this very edge.
    assign next_full = bank_full[~drain_sel] || (fill_last && (fill_sel != drain_sel));
    assign out_last  = out_valid && row_last;
    assign dbg_state = state_q;

    // Next-state and handshake outputs of the drain-side FSM.
    always_comb begin
        state_d    = state_q;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_FILL: begin
                if (bank_full[drain_sel] || (fill_last && (fill_sel == drain_sel))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (row_last) begin
                        state_d = S_DONE;
                    end else if (slab_end) begin
                        state_d = next_full ? S_DRAIN : S_FILL;
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
    end

    // State register, counters and bank occupancy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FILL;
            word_cnt  <= '0;
            slab_row  <= '0;
            row_cnt   <= '0;
            fill_sel  <= 1'b0;
            drain_sel <= 1'b0;
            bank_full <= '0;
        end else begin
            state_q <= state_d;
            if (out_fire) begin
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                if (row_last || slab_end) begin
                    // Rows past ROW-1 in a partial last slab are simply dropped.
                    slab_row             <= '0;
                    bank_full[drain_sel] <= 1'b0;
`ifdef R2N_PINGPONG_EN
                    drain_sel            <= ~drain_sel;
`endif
                end else begin
                    slab_row <= slab_row + 1'b1;
                end
            end
            if (in_fire) begin
                if (fill_last) begin
                    word_cnt            <= '0;
                    bank_full[fill_sel] <= 1'b1;
`ifdef R2N_PINGPONG_EN
                    fill_sel            <= ~fill_sel;
`endif
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            if (state_q == S_DONE) begin
                slab_row <= '0;
                row_cnt  <= '0;
            end
        end
    end

    // Scatter an accepted word's tiles into the fill bank (contents need no reset).
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int j = 0; j < WPS; j++) begin
                if (word_cnt == WC_W'(j)) begin
                    for (int k = 0; k < NUM_CORES; k++) begin
                        for (int r = 0; r < BLOCK_SIZE; r++) begin
                            for (int c = 0; c < BLOCK_SIZE; c++) begin
                                bank[fill_sel][k*BLOCK_SIZE+r][j*BLOCK_SIZE+c] <=
                                    in_data[((NUM_CORES-1-k)*CHUNK_SIZE +
                                             (CHUNK_SIZE-1-(r*BLOCK_SIZE+c)))*WIDTH +: WIDTH];
                            end
                        end
                    end
                end
            end
        end
    end

    // Row output: drain-bank row picked by the slab-row counter, zero when idle.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < SLAB; i++) begin
            if (out_valid && (slab_row == SR_W'(i))) begin
                for (int n = 0; n < COL; n++) begin
                    out_data[(COL-1-n)*WIDTH +: WIDTH] = bank[drain_sel][i][n];
                end
            end
        end
    end

endmodule

// File: tb/tb_r2n_buffer.sv
// tb_r2n_buffer: directed sequence with randomized data and backpressure for r2n_buffer.
// The bench tiles a reference matrix into input words and expects its rows back.
module tb_r2n_buffer;
    localparam int WIDTH      = 16;
    localparam int FRAC_WIDTH = 8;
    localparam int BLOCK_SIZE = 2;
    localparam int CHUNK_SIZE = 4;
    localparam int NUM_CORES  = 2;
    localparam int COL        = 4;
    localparam int ROW        = 6;
    localparam int SLAB       = BLOCK_SIZE * NUM_CORES;
    localparam int WPS        = COL / BLOCK_SIZE;
    localparam int NSLAB      = (ROW + SLAB - 1) / SLAB;
    localparam int IW         = WIDTH * CHUNK_SIZE * NUM_CORES;
    localparam int RW         = WIDTH * COL;
    localparam int TIMEOUT    = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          out_last;
    logic          frame_done;
    logic [1:0]    dbg_state;

    // Clock.
    always #5 clk = ~clk;

    r2n_buffer #(
        .WIDTH(WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .BLOCK_SIZE(BLOCK_SIZE),
        .CHUNK_SIZE(CHUNK_SIZE), .ROW(ROW), .COL(COL), .NUM_CORES(NUM_CORES)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errs = 0;
    int done_pulses = 0;
    int frames_exp = 0;
    int last_wait = 0;

    logic [RW-1:0]    exp_q[$];
    int               exp_row_q[$];
    logic [WIDTH-1:0] mat [NSLAB*SLAB][COL];

    // Count frame_done pulses (high for whole cycles, so one negedge per pulse).
    always @(negedge clk) if (frame_done === 1'b1) done_pulses++;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_matrix(input bit rnd);
        for (int r = 0; r < NSLAB*SLAB; r++)
            for (int n = 0; n < COL; n++)
                mat[r][n] = rnd ? WIDTH'($urandom) : WIDTH'(r*16 + n);
    endtask

    // Tile word j of slab s from the reference matrix.
    function automatic logic [IW-1:0] make_word(input int s, input int j);
        logic [IW-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_CORES; k++)
            for (int r = 0; r < BLOCK_SIZE; r++)
                for (int c = 0; c < BLOCK_SIZE; c++)
                    w[((NUM_CORES-1-k)*CHUNK_SIZE + CHUNK_SIZE-1-(r*BLOCK_SIZE+c))*WIDTH +: WIDTH] =
                        mat[s*SLAB + k*BLOCK_SIZE + r][j*BLOCK_SIZE + c];
        return w;
    endfunction

    function automatic logic [RW-1:0] make_row(input int r);
        logic [RW-1:0] v;
        for (int n = 0; n < COL; n++) v[(COL-1-n)*WIDTH +: WIDTH] = mat[r][n];
        return v;
    endfunction

    task automatic push_slab_rows(input int s);
        for (int r = s*SLAB; r < s*SLAB + SLAB && r < ROW; r++) begin
            exp_q.push_back(make_row(r));
            exp_row_q.push_back(r);
        end
    endtask

    // Driver: optional idle gap, then hold the word until accepted.
    task automatic send_word(input logic [IW-1:0] w, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (in_ready !== 1'b1 && t < TIMEOUT) begin @(posedge clk); #1; t++; end
        if (t >= TIMEOUT) begin
            n_checks++; n_errs++;
            $error("FAIL in_ready_timeout: observed no accept after %0d cycles expected accept", t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Receiver: random backpressure, stability during stalls, row/last/frame_done checks.
    task automatic recv_row(input int pct);
        int t;
        int idx;
        bit stalled;
        bit got;
        logic [RW-1:0] held;
        logic [RW-1:0] exp;
        t = 0; idx = -1; stalled = 0; got = 0; held = '0;
        while (!got && t < TIMEOUT) begin
            if (stalled) begin
                check("stall_valid", RW'(out_valid), RW'(1));
                check("stall_data", out_data, held);
            end
            out_ready = ($urandom_range(0, 99) < pct);
            if (out_valid === 1'b1) begin
`ifndef R2N_PINGPONG_EN
                check("in_ready_in_drain", RW'(in_ready), RW'(0));
`endif
                if (out_ready) begin
                    exp = exp_q.pop_front();
                    idx = exp_row_q.pop_front();
                    check("row_data", out_data, exp);
                    check("out_last", RW'(out_last), RW'(idx == ROW-1));
                    last_wait = t;
                    got = 1;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = out_data;
                end
            end else begin
                stalled = 0;
            end
            @(posedge clk); #1;
            if (!got) t++;
        end
        out_ready = 1'b0;
        if (!got) begin
            n_checks++; n_errs++;
            $error("FAIL row_timeout: observed no row after %0d cycles expected row", t);
        end else if (idx == ROW-1) begin
            check("frame_done_pulse", RW'(frame_done), RW'(1));
            check("done_valid_low", RW'(out_valid), RW'(0));
            @(posedge clk); #1;
            check("frame_done_once", RW'(frame_done), RW'(0));
        end
    endtask

    task automatic run_slab(input int s, input int pct, input int maxgap);
        for (int j = 0; j < WPS; j++)
            send_word(make_word(s, j), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        check("valid_latency", RW'(out_valid), RW'(1));
        push_slab_rows(s);
        for (int r = s*SLAB; r < s*SLAB + SLAB && r < ROW; r++) recv_row(pct);
        if (s < NSLAB-1) check("slab_gap_valid_low", RW'(out_valid), RW'(0));
    endtask

    task automatic run_frame(input bit rnd, input int pct, input int maxgap);
        load_matrix(rnd);
        for (int s = 0; s < NSLAB; s++) run_slab(s, pct, maxgap);
        frames_exp++;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_in_ready"}, RW'(in_ready), RW'(0));
        check({tag, "_out_valid"}, RW'(out_valid), RW'(0));
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_out_last"}, RW'(out_last), RW'(0));
        check({tag, "_frame_done"}, RW'(frame_done), RW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_row_q.delete();
        @(posedge clk); #1;
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", RW'(in_ready), RW'(0));
        check("rst_out_valid", RW'(out_valid), RW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_last", RW'(out_last), RW'(0));
        check("rst_frame_done", RW'(frame_done), RW'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", RW'(in_ready), RW'(1));
        @(posedge clk); #1;

        // Pattern frame with an always-ready sink.
        run_frame(1'b0, 100, 0);
        // Random data with random backpressure.
        for (int f = 0; f < 3; f++) run_frame(1'b1, 50, 0);
        // Gaps between input words as well.
        for (int f = 0; f < 3; f++) run_frame(1'b1, 70, 3);

        // Reset after one word of slab 0, then a clean frame.
        load_matrix(1'b0);
        send_word(make_word(0, 0), 0);
        pulse_reset("rst_mid_fill");
        run_frame(1'b0, 100, 0);

        // Reset while a slab is draining.
        load_matrix(1'b1);
        for (int j = 0; j < WPS; j++) send_word(make_word(0, j), 0);
        check("pre_rst_valid", RW'(out_valid), RW'(1));
        pulse_reset("rst_mid_drain");
        run_frame(1'b1, 60, 1);

        // Reset after a complete slab so the row counter has advanced.
        load_matrix(1'b1);
        run_slab(0, 100, 0);
        pulse_reset("rst_mid_frame");
        run_frame(1'b1, 80, 2);

`ifdef R2N_PINGPONG_EN
        // Back-to-back frames with both sides always ready.
        load_matrix(1'b1);
        for (int f = 0; f < 2; f++) for (int s = 0; s < NSLAB; s++) push_slab_rows(s);
        fork
            begin
                for (int f = 0; f < 2; f++)
                    for (int s = 0; s < NSLAB; s++)
                        for (int j = 0; j < WPS; j++) send_word(make_word(s, j), 0);
            end
            begin
                for (int i = 0; i < 2*ROW; i++) begin
                    recv_row(100);
                    if (i % ROW != 0) check("pp_no_bubble", RW'(last_wait), RW'(0));
                end
            end
        join
        frames_exp += 2;
`endif

        repeat (2) @(posedge clk);
        #1;
        check("frame_done_count", RW'(done_pulses), RW'(frames_exp));
        check("queue_empty", RW'(exp_q.size()), RW'(0));
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "timeout");
    end

endmodule
